// File: rtl/mem_wb_pkg.sv
// Shared constants for the MEM->WB stage: load-size codes and skid occupancy states.
package mem_wb_pkg;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

endpackage

// File: rtl/mem_wb_load_align.sv
// Load-data alignment: picks the addressed byte/half lane and sign- or zero-extends it.
module mem_wb_load_align
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter bit          LOAD_EXT_EN = 1'b1
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_fill;
  logic        w_half_fill;

  always_comb begin
    w_byte      = i_data[{i_offset, 3'b000} +: 8];
    w_half      = i_offset[1] ? i_data[31:16] : i_data[15:0];
    w_byte_fill = ~i_unsigned & w_byte[7];
    w_half_fill = ~i_unsigned & w_half[15];
    o_data      = i_data;
    if (LOAD_EXT_EN) begin
      case (i_size)
        LOAD_BYTE: o_data = {{(DATA_W-8){w_byte_fill}}, w_byte};
        LOAD_HALF: o_data = {{(DATA_W-16){w_half_fill}}, w_half};
        default:   o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: 2-entry skid buffer with flush, load alignment and write-back select.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter bit          ZERO_REG_WP = 1'b1,
  parameter bit          LOAD_EXT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     mem_rdata_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic [1:0]            load_size_in,
  input  logic                  load_unsigned_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     wb_data_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  reg_write_out
);

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
  } entry_t;

  occ_e   r_state;
  occ_e   w_state_nxt;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_beat;

  logic [DATA_W-1:0] w_load_data;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;

  mem_wb_load_align #(
    .DATA_W      (DATA_W),
    .LOAD_EXT_EN (LOAD_EXT_EN)
  ) u_align (
    .i_data     (mem_rdata_in),
    .i_offset   (alu_result_in[1:0]),
    .i_size     (load_size_in),
    .i_unsigned (load_unsigned_in),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_beat.data = mem_to_reg_in ? w_load_data : alu_result_in;
    w_beat.rd   = write_reg_in;
    w_beat.we   = reg_write_in;
  end

  // Both handshake flags come straight from the occupancy register, so
  // in_ready never has a combinational path from out_ready.
  assign in_ready   = (r_state != OCC_TWO);
  assign out_valid  = (r_state != OCC_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = OCC_ONE;
            w_main_ld   = 1'b1;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = OCC_TWO;
            w_skid_ld   = 1'b1;
          end else if (w_in_fire && w_out_fire) begin
            w_main_ld   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = OCC_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_ld) begin
        r_main <= w_beat;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld) begin
        r_skid <= w_beat;
      end
    end
  end

  assign wb_data_out   = r_main.data;
  assign write_reg_out = r_main.rd;
  assign reg_write_out = out_valid & r_main.we &
                         ~(ZERO_REG_WP && (r_main.rd == '0));

endmodule
